// File: rtl/grid_edit_ctrl_pkg.sv
// Purpose : shared key codes, undo entry layout and index-width helper for the grid editor.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package grid_pkg;

  localparam logic [4:0] KEY_UP    = 5'b10010;
  localparam logic [4:0] KEY_LEFT  = 5'b10100;
  localparam logic [4:0] KEY_RIGHT = 5'b10110;
  localparam logic [4:0] KEY_DOWN  = 5'b11000;
  localparam logic [4:0] KEY_PAINT = 5'b11010;
  localparam logic [4:0] KEY_BLOCK = 5'b11011;
  localparam logic [4:0] KEY_UNDO  = 5'b11100;

  // Largest board is 16x16 = 256 cells, so 8 index bits cover every legal size.
  localparam int IDX_MAX_W = 8;

  typedef struct packed {
    logic                 plane;  // 0 = paint plane, 1 = block plane
    logic [IDX_MAX_W-1:0] idx;    // cell index y*GRID_W+x
  } undo_entry_t;

  function automatic int idx_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/grid_edit_ctrl_if.sv
// Purpose : bundles the keypad/target inputs and the board state outputs of the grid editor.
// Latency : n/a (wiring only).
// Backpressure: none; keys are single-cycle pulses. Ports: master = keypad/display side, slave = editor.
interface grid_edit_ctrl_if
  import grid_pkg::*;
#(
  parameter int GRID_W     = 10,
  parameter int GRID_H     = 10,
  parameter int UNDO_DEPTH = 8,
  parameter int CNT_W      = 10
);
  localparam int N  = GRID_W * GRID_H;
  localparam int LW = $clog2(UNDO_DEPTH) + 1;

  logic [4:0]       key_pulse;
  logic [N-1:0]     target;
  logic [3:0]       sel_x;
  logic [3:0]       sel_y;
  logic [N-1:0]     paint;
  logic [N-1:0]     block;
  logic             event_off;
  logic [CNT_W-1:0] edit_cnt;
  logic [LW-1:0]    undo_lvl;
  logic             solved;

  modport master (
    output key_pulse, target,
    input  sel_x, sel_y, paint, block, event_off, edit_cnt, undo_lvl, solved
  );

  modport slave (
    input  key_pulse, target,
    output sel_x, sel_y, paint, block, event_off, edit_cnt, undo_lvl, solved
  );
endinterface

// File: rtl/grid_edit_ctrl_undo_lifo.sv
// Purpose : ring-buffer LIFO of undo entries; a push when full overwrites the oldest entry.
// Latency : push/pop take effect at the clock edge; o_top is combinational from the stored entries.
// Backpressure: none; never full-blocking, pop when empty is ignored. Ports: i_push/i_pop/i_dat in, o_top/o_lvl out.
module undo_lifo
  import grid_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  undo_entry_t                i_dat,
  output undo_entry_t                o_top,
  output logic [$clog2(DEPTH):0]     o_lvl
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  undo_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wp;   // next write slot; when full it also points at the oldest entry
  logic [LW-1:0] r_lvl;
  logic [PW-1:0] w_rp;

  assign w_rp  = r_wp - PW'(1);
  assign o_top = r_mem[w_rp];
  assign o_lvl = r_lvl;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_lvl <= '0;
    end else if (i_push) begin
      r_wp <= r_wp + PW'(1);
      if (r_lvl != LW'(DEPTH)) r_lvl <= r_lvl + LW'(1);
    end else if (i_pop && (r_lvl != '0)) begin
      r_wp  <= w_rp;
      r_lvl <= r_lvl - LW'(1);
    end
  end
endmodule

// File: rtl/grid_edit_ctrl.sv
// Purpose : nonogram grid editor - cursor, paint/block planes, undo, edit counter, solved flag.
// Latency : state updates 1 cycle after the key edge; solved 2 cycles after the key.
// Backpressure: none; one key per clock accepted back-to-back. Ports: clk, rst, bus (slave: key_pulse/target in, board state out).
module grid_edit_ctrl
  import grid_pkg::*;
#(
  parameter int GRID_W     = 10,
  parameter int GRID_H     = 10,
  parameter int UNDO_DEPTH = 8,
  parameter int CNT_W      = 10
) (
  input  logic            clk,
  input  logic            rst,
  grid_edit_ctrl_if.slave bus
);
  localparam int N  = GRID_W * GRID_H;
  localparam int IW = idx_w(GRID_W, GRID_H);
  localparam int LW = $clog2(UNDO_DEPTH) + 1;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_sel_x, r_sel_y, w_nx, w_ny;
  logic [N-1:0]     r_paint, r_block;
  logic [CNT_W-1:0] r_cnt;
  logic             r_solved;

  logic [4:0]       w_key;
  logic [IW-1:0]    w_idx;
  logic [N-1:0]     w_cur_mask, w_top_mask, w_paint_flip, w_block_flip;
  logic             w_paint_ok, w_block_ok, w_push, w_pop;
  undo_entry_t      w_push_dat, w_top;
  logic [LW-1:0]    w_lvl;
  int               w_top_pos;

  assign w_key      = bus.key_pulse;
  assign w_idx      = IW'(int'(r_sel_y) * GRID_W + int'(r_sel_x));
  assign w_cur_mask = N'(1) << w_idx;
  assign w_top_mask = N'(1) << w_top.idx;
  assign w_top_pos  = int'(w_top.idx);

  // A paint is refused on a blocked cell and vice versa, so the planes never overlap.
  assign w_paint_ok = (w_key == KEY_PAINT) && !r_block[w_idx];
  assign w_block_ok = (w_key == KEY_BLOCK) && !r_paint[w_idx];
  assign w_push     = w_paint_ok || w_block_ok;
  assign w_pop      = (w_key == KEY_UNDO) && (w_lvl != '0);

  assign w_push_dat.plane = w_block_ok;
  assign w_push_dat.idx   = IDX_MAX_W'(w_idx);

  undo_lifo #(.DEPTH(UNDO_DEPTH)) u_undo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_dat  (w_push_dat),
    .o_top  (w_top),
    .o_lvl  (w_lvl)
  );

  // Undo toggles blindly: LIFO order guarantees the recorded bit is still in its post-edit state.
  assign w_paint_flip = (w_paint_ok ? w_cur_mask : '0) ^ ((w_pop && !w_top.plane) ? w_top_mask : '0);
  assign w_block_flip = (w_block_ok ? w_cur_mask : '0) ^ ((w_pop &&  w_top.plane) ? w_top_mask : '0);

  always_comb begin
    w_nx = r_sel_x;
    w_ny = r_sel_y;
    case (w_key)
      KEY_UP:    w_ny = (r_sel_y == 4'd0) ? 4'(GRID_H - 1) : r_sel_y - 4'd1;
      KEY_DOWN:  w_ny = (r_sel_y == 4'(GRID_H - 1)) ? 4'd0 : r_sel_y + 4'd1;
      KEY_LEFT:  w_nx = (r_sel_x == 4'd0) ? 4'(GRID_W - 1) : r_sel_x - 4'd1;
      KEY_RIGHT: w_nx = (r_sel_x == 4'(GRID_W - 1)) ? 4'd0 : r_sel_x + 4'd1;
      KEY_UNDO: begin
        if (w_pop) begin
          w_nx = 4'(w_top_pos % GRID_W);
          w_ny = 4'(w_top_pos / GRID_W);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_IDLE) && ((w_key == KEY_PAINT) || (w_key == KEY_BLOCK)))
      w_state_nxt = ST_ACTIVE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel_x  <= '0;
      r_sel_y  <= '0;
      r_paint  <= '0;
      r_block  <= '0;
      r_cnt    <= '0;
      r_solved <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel_x  <= w_nx;
      r_sel_y  <= w_ny;
      r_paint  <= r_paint ^ w_paint_flip;
      r_block  <= r_block ^ w_block_flip;
      if ((w_push || w_pop) && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      r_solved <= (r_paint == bus.target);
    end
  end

  assign bus.sel_x     = r_sel_x;
  assign bus.sel_y     = r_sel_y;
  assign bus.paint     = r_paint;
  assign bus.block     = r_block;
  assign bus.event_off = (r_state == ST_IDLE);
  assign bus.edit_cnt  = r_cnt;
  assign bus.undo_lvl  = w_lvl;
  assign bus.solved    = r_solved;
endmodule

// File: tb/tb_grid_edit_ctrl.sv
// Purpose : self-checking bench for grid_edit_ctrl using a reference model and an expected-result queue.
// Latency : each key is driven 1 ns after an edge and checked 1 ns after the next edge.
// Backpressure: n/a.
module tb_grid_edit_ctrl;
  import grid_pkg::*;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int D  = 8;
  localparam int CW = 10;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  grid_edit_ctrl_if #(.GRID_W(W), .GRID_H(H), .UNDO_DEPTH(D), .CNT_W(CW)) bus ();

  grid_edit_ctrl #(.GRID_W(W), .GRID_H(H), .UNDO_DEPTH(D), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           x, y, cnt, lvl;
    logic [N-1:0] paint, block;
    bit           off, solved;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // reference model state
  int           m_x, m_y, m_cnt;
  logic [N-1:0] m_paint, m_block;
  bit           m_off, m_solved;
  int           uq[$];   // plane*1000 + idx, newest at back

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_cnt = 0;
    m_paint = '0; m_block = '0;
    m_off = 1'b1; m_solved = 1'b0;
    uq.delete();
  endtask

  task automatic upush(input int e);
    uq.push_back(e);
    if (uq.size() > D) void'(uq.pop_front());
    if (m_cnt < (1 << CW) - 1) m_cnt++;
  endtask

  task automatic model(input logic [4:0] k);
    int i, e;
    m_solved = (m_paint == bus.target);
    i = m_y * W + m_x;
    case (k)
      KEY_UP:    m_y = (m_y == 0) ? H - 1 : m_y - 1;
      KEY_DOWN:  m_y = (m_y == H - 1) ? 0 : m_y + 1;
      KEY_LEFT:  m_x = (m_x == 0) ? W - 1 : m_x - 1;
      KEY_RIGHT: m_x = (m_x == W - 1) ? 0 : m_x + 1;
      KEY_PAINT: begin
        m_off = 1'b0;
        if (!m_block[i]) begin m_paint[i] = ~m_paint[i]; upush(i); end
      end
      KEY_BLOCK: begin
        m_off = 1'b0;
        if (!m_paint[i]) begin m_block[i] = ~m_block[i]; upush(1000 + i); end
      end
      KEY_UNDO: begin
        if (uq.size() > 0) begin
          e = uq.pop_back();
          if (e >= 1000) begin e -= 1000; m_block[e] = ~m_block[e]; end
          else m_paint[e] = ~m_paint[e];
          m_x = e % W;
          m_y = e / W;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end
      default: ;
    endcase
  endtask

  // Drive one key for one edge; expected state goes into the queue, then is popped against the DUT.
  task automatic step(input logic [4:0] k);
    exp_t e;
    bus.key_pulse = k;
    model(k);
    e.x = m_x; e.y = m_y; e.cnt = m_cnt; e.lvl = uq.size();
    e.paint = m_paint; e.block = m_block; e.off = m_off; e.solved = m_solved;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.key_pulse = '0;
    e = sb.pop_front();
    chk("sel_x", bus.sel_x, e.x);
    chk("sel_y", bus.sel_y, e.y);
    chk("paint", bus.paint, e.paint);
    chk("block", bus.block, e.block);
    chk("event_off", bus.event_off, e.off);
    chk("edit_cnt", bus.edit_cnt, e.cnt);
    chk("undo_lvl", bus.undo_lvl, e.lvl);
    chk("solved", bus.solved, e.solved);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sel_x"}, bus.sel_x, 0);
    chk({tag, "_sel_y"}, bus.sel_y, 0);
    chk({tag, "_paint"}, bus.paint, 0);
    chk({tag, "_block"}, bus.block, 0);
    chk({tag, "_event_off"}, bus.event_off, 1);
    chk({tag, "_edit_cnt"}, bus.edit_cnt, 0);
    chk({tag, "_undo_lvl"}, bus.undo_lvl, 0);
    chk({tag, "_solved"}, bus.solved, 0);
  endtask

  logic [4:0] keys [10];

  initial begin
    keys = '{KEY_UP, KEY_LEFT, KEY_RIGHT, KEY_DOWN, KEY_PAINT, KEY_BLOCK, KEY_UNDO,
             5'b00000, 5'b10011, 5'b11111};
    bus.key_pulse = '0;
    bus.target    = '0;
    bus.target[0]  = 1'b1;
    bus.target[11] = 1'b1;
    model_reset();

    #1 rst = 1'b1;
    #1 check_reset("por");
    #10 rst = 1'b0;

    // wrap-around moves
    step(KEY_LEFT); step(KEY_UP);
    chk("wrap_lu_x", bus.sel_x, 9);
    chk("wrap_lu_y", bus.sel_y, 9);
    step(KEY_RIGHT); step(KEY_DOWN);
    chk("wrap_rd_x", bus.sel_x, 0);
    chk("wrap_rd_y", bus.sel_y, 0);

    // paint at (2,3) then a suppressed block on the same cell
    step(KEY_RIGHT); step(KEY_RIGHT);
    step(KEY_DOWN); step(KEY_DOWN); step(KEY_DOWN);
    step(KEY_PAINT);
    chk("paint32", bus.paint[32], 1);
    chk("paint_cnt", bus.edit_cnt, 1);
    step(KEY_BLOCK);
    chk("block32_suppressed", bus.block[32], 0);
    chk("block_cnt", bus.edit_cnt, 1);

    // move away, undo returns the cursor and clears the cell
    step(KEY_RIGHT); step(KEY_RIGHT); step(KEY_RIGHT);
    step(KEY_DOWN); step(KEY_DOWN);
    step(KEY_UNDO);
    chk("undo_paint32", bus.paint[32], 0);
    chk("undo_sel_x", bus.sel_x, 2);
    chk("undo_sel_y", bus.sel_y, 3);
    chk("undo_cnt", bus.edit_cnt, 2);
    step(KEY_UNDO);
    chk("undo_empty_cnt", bus.edit_cnt, 2);

    // ring overwrite: 9 edits into an 8-deep history
    step(KEY_LEFT); step(KEY_LEFT);
    step(KEY_UP); step(KEY_UP); step(KEY_UP);
    for (int c = 0; c < 9; c++) begin
      step(KEY_PAINT);
      step(KEY_RIGHT);
    end
    chk("ring_full_lvl", bus.undo_lvl, D);
    for (int c = 0; c < 9; c++) step(KEY_UNDO);
    chk("ring_cells_1_8", bus.paint[8:1], 0);
    chk("ring_cell0", bus.paint[0], 1);
    chk("ring_lvl", bus.undo_lvl, 0);

    // random key mix, including unknown codes
    for (int r = 0; r < 300; r++) step(keys[$urandom_range(0, 9)]);

    // reset in the middle of a stream
    step(KEY_PAINT); step(KEY_RIGHT); step(KEY_BLOCK); step(KEY_DOWN); step(KEY_PAINT);
    #2 rst = 1'b1;
    #1 check_reset("midrst");
    model_reset();
    #2 rst = 1'b0;
    step(5'b00000);
    step(KEY_UNDO);
    chk("post_rst_undo_cnt", bus.edit_cnt, 0);

    // solved flag against target {0,11}
    step(KEY_PAINT); step(KEY_RIGHT); step(KEY_DOWN); step(KEY_PAINT);
    chk("solved_lag", bus.solved, 0);
    step(5'b00000);
    chk("solved_set", bus.solved, 1);
    step(KEY_UNDO);
    step(5'b00000);
    chk("solved_clear", bus.solved, 0);

    // counter saturation on an unblocked cell
    for (int s = 0; s < 1040; s++) step(KEY_PAINT);
    chk("cnt_sat", bus.edit_cnt, (1 << CW) - 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/grid_edit_ctrl.md
# grid_edit_ctrl

Parametrised nonogram grid editor: holds cursor position and the paint/block planes for a GRID_W × GRID_H board and applies one keypad command per clock. Adds an undo stack of the last UNDO_DEPTH effective edits, an edit counter and a registered solved flag against a target pattern. Sits between the keypad pulse decoder and the display/judge logic, replacing the fixed 10×10 controller.

## Interface
- GRID_W, 10, columns (2..16)
- GRID_H, 10, rows (2..16)
- UNDO_DEPTH, 8, undo entries kept (power of two, ≥2)
- CNT_W, 10, edit counter width
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- key_pulse  in  5  one-clock key code; unknown codes ignored
- target  in  GRID_W*GRID_H  solution pattern, bit y*GRID_W+x
- sel_x  out  4  cursor column, 0..GRID_W-1
- sel_y  out  4  cursor row, 0..GRID_H-1
- paint  out  GRID_W*GRID_H  painted cells, bit y*GRID_W+x
- block  out  GRID_W*GRID_H  blocked (X-marked) cells, same indexing
- event_off  out  1  1 after reset until first paint/block key
- edit_cnt  out  CNT_W  effective edits + undos, saturating
- undo_lvl  out  $clog2(UNDO_DEPTH)+1  entries available to undo
- solved  out  1  paint == target, registered

## Operation
- Key codes: UP 5'b10010 (y-1), LEFT 5'b10100 (x-1), RIGHT 5'b10110 (x+1), DOWN 5'b11000 (y+1), PAINT 5'b11010, BLOCK 5'b11011, UNDO 5'b11100.
- Moves wrap: x 0 ← LEFT → GRID_W-1; x GRID_W-1 → RIGHT → 0; same for y with GRID_H.
- Cell index i = sel_y*GRID_W + sel_x, width $clog2(GRID_W*GRID_H).
- PAINT: if block[i]==0, toggle paint[i], push {plane=0,i}, edit_cnt+1. Else no change, no push.
- BLOCK: if paint[i]==0, toggle block[i], push {plane=1,i}, edit_cnt+1. Else no change.
- PAINT/BLOCK always clear event_off (even when suppressed); other keys never change it.
- UNDO, undo_lvl>0: pop top entry, toggle the recorded plane bit unconditionally (LIFO keeps planes consistent), move cursor to that cell, edit_cnt+1. undo_lvl==0: no-op.
- Push when undo_lvl==UNDO_DEPTH: overwrite oldest entry (ring), undo_lvl stays UNDO_DEPTH.
- Moves do not touch the undo stack.
- edit_cnt saturates at 2^CNT_W-1.
- solved recomputed every cycle from registered paint and current target.

## Timing
- Command sampled at posedge where key_pulse valid; sel_x/sel_y/paint/block/edit_cnt/undo_lvl/event_off reflect it after that edge (1-cycle latency).
- solved lags paint by one cycle (2 cycles from key).
- Back-to-back keys on consecutive cycles each take effect; no busy state.
- Reset values: sel_x=0, sel_y=0, paint=0, block=0, event_off=1, edit_cnt=0, undo_lvl=0, solved=0; undo pointers cleared; rst mid-sequence discards all history immediately.
- Control FSM: IDLE (event_off=1) → ACTIVE on first PAINT/BLOCK; ACTIVE exits only on rst.

## Structure
- Package grid_pkg: key code localparams, undo entry struct {plane, idx}, index width function.
- Sub-module undo_lifo: ring-buffer LIFO, DEPTH×(1+idx width), push/pop/level, overwrite-oldest on full push; push and pop never simultaneous.
- Top: cursor regs, plane regs, counter, event FSM, solved register.

## Test plan
- Reset then LEFT, UP -> sel_x=9, sel_y=9 (10×10); RIGHT, DOWN -> 0,0.
- PAINT at (2,3) -> paint[32]=1, event_off=0, edit_cnt=1, undo_lvl=1; BLOCK there -> block[32] stays 0, edit_cnt=1.
- PAINT (2,3), move to (5,5), UNDO -> paint[32]=0, sel=(2,3), undo_lvl=0, edit_cnt=2; further UNDO -> no change.
- UNDO_DEPTH=8: 9 PAINT toggles on cells 0..8 then 9 UNDO -> cells 8..1 cleared, cell 0 still painted, undo_lvl=0.
- target=cells {0,11}; paint both -> solved=1 two cycles after second key; UNDO -> solved=0.
- rst asserted mid-stream after 3 edits -> all outputs to reset values same cycle; UNDO after -> no-op.
